// File: rtl/b2bd_pkg.sv
// Shared types and helpers for the shared binary-to-BCD converter.
package b2bd_pkg;

  localparam int DIGIT_W   = 4;
  // Widest BCD field the digit-correction helper handles; cores zero-extend into it.
  localparam int BCD_MAX_W = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2bd_state_t;

  // Double-dabble correction: every BCD digit that is 5 or more gets 3 added,
  // so that the following left shift carries correctly into the next digit.
  function automatic logic [BCD_MAX_W-1:0] add3_digits(input logic [BCD_MAX_W-1:0] bcd);
    logic [BCD_MAX_W-1:0] r;
    r = bcd;
    for (int d = 0; d < BCD_MAX_W / DIGIT_W; d++) begin
      if (bcd[d*DIGIT_W +: DIGIT_W] >= 4'd5)
        r[d*DIGIT_W +: DIGIT_W] = bcd[d*DIGIT_W +: DIGIT_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/b2bd_seq_core.sv
// Sequential double-dabble engine: one operand per start, BIN_W shift cycles,
// then a single DONE cycle that presents the result.
//
//  state | meaning
//  IDLE  | waiting for start; shift registers hold the last operand/result
//  SHIFT | one add-3 correction plus left shift per cycle, BIN_W cycles
//  DONE  | done pulse high, bcd_out valid, busy still high
module b2bd_seq_core
  import b2bd_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int BCD_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  b2bd_state_t          state;
  logic [BIN_W-1:0]     bin_sr;
  logic [BCD_W-1:0]     bcd_sr;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_MAX_W-1:0] corr_wide;
  logic [BCD_W-1:0]     corr;
  logic                 unused_hi;

  // Corrected digits of the current BCD accumulator, ready to be shifted.
  assign corr_wide = add3_digits(BCD_MAX_W'(bcd_sr));
  assign corr      = corr_wide[BCD_W-1:0];
  // The top corrected bit is shifted out; the parameter check guarantees it is always zero.
  assign unused_hi = ^corr_wide[BCD_MAX_W-1:BCD_W-1];

  // Conversion sequencer with registered busy/done/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= operand;
            bcd_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {corr[BCD_W-2:0], bin_sr, 1'b0};
          cnt              <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            bcd_out <= {corr[BCD_W-2:0], bin_sr[BIN_W-1]};
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/b2bd_share_arb.sv
// Round-robin front end that shares one double-dabble core among NREQ requesters.
// Grants only while the core is idle; requests arriving while busy are simply
// re-sampled once the core returns to IDLE.
module b2bd_share_arb
  import b2bd_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BIN_W = 8,
  parameter int BCD_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BIN_W-1:0]   bin_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [BCD_W-1:0]        bcd_out,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam longint unsigned DEC_RANGE = longint'(10) ** (BCD_W / DIGIT_W);
  localparam longint unsigned BIN_MAX   = (longint'(1) << BIN_W) - 1;

  // Reject parameter sets whose BCD field cannot hold the largest operand.
  generate
    if (NREQ < 2 || (BCD_W % DIGIT_W) != 0 || BCD_W >= BCD_MAX_W || DEC_RANGE <= BIN_MAX) begin : g_bad_params
      $error("b2bd_share_arb: illegal NREQ/BIN_W/BCD_W combination");
    end
  endgenerate

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             start;
  logic [BIN_W-1:0] operand;
  logic [NREQ-1:0]  owner_oh;
  logic             core_busy;
  logic             core_done;

  // Round-robin pick: first active request starting just after the last winner.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign start   = found & ~core_busy;
  assign operand = bin_in[int'(win)*BIN_W +: BIN_W];

  // Grant pulse, owner and round-robin pointer update on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDX_W'(NREQ - 1);
      owner    <= '0;
      gnt      <= '0;
      owner_oh <= '0;
    end else begin
      gnt <= '0;
      if (start) begin
        gnt      <= NREQ'(1) << win;
        owner_oh <= NREQ'(1) << win;
        owner    <= win;
        ptr      <= win;
      end
    end
  end

  b2bd_seq_core #(
    .BIN_W (BIN_W),
    .BCD_W (BCD_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (operand),
    .busy    (core_busy),
    .done    (core_done),
    .bcd_out (bcd_out)
  );

  // Done is steered to the owner; both terms are registers, so no glitches.
  assign done = {NREQ{core_done}} & owner_oh;
  assign busy = core_busy;

endmodule

// File: tb/tb_b2bd_share_arb.sv
// Directed bench for the shared binary-to-BCD converter.
module tb_b2bd_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] bin_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [11:0] bcd_out;
  logic [1:0]  owner;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int gnt_cyc = 0;

  b2bd_share_arb #(.NREQ(4), .BIN_W(8), .BCD_W(12)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .bin_in  (bin_in),
    .gnt     (gnt),
    .done    (done),
    .bcd_out (bcd_out),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // Wait for a grant, check it, optionally withdraw the request, then check the result.
  task automatic do_conv(input int who, input logic [11:0] exp_bcd, input bit drop);
    int n;
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (gnt != 4'b0) seen = 1;
    end
    gnt_cyc = cyc;
    chk("gnt", 32'(gnt), 32'(4'b0001 << who));
    if (drop) req[who] = 1'b0;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done != 4'b0) seen = 1;
    end
    chk("latency", 32'(n), 32'd8);
    chk("done", 32'(done), 32'(4'b0001 << who));
    chk("bcd", 32'(bcd_out), 32'(exp_bcd));
  endtask

  initial begin
    int prev;
    int n;
    bit seen;

    // 1: reset held with all requests active
    rst_n  = 1'b0;
    req    = 4'hF;
    bin_in = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_bcd", 32'(bcd_out), 32'h000);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    req   = 4'h0;
    rst_n = 1'b1;

    // 2: single request, max operand
    bin_in = {8'd0, 8'd0, 8'd0, 8'd255};
    req    = 4'b0001;
    do_conv(0, 12'h255, 1);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'h0);
    chk("bcd_hold", 32'(bcd_out), 32'h255);

    // 3: all four requesting from a fresh pointer
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    bin_in = {8'd199, 8'd100, 8'd9, 8'd0};
    req    = 4'hF;
    do_conv(0, 12'h000, 1);
    prev = gnt_cyc;
    do_conv(1, 12'h009, 1);
    chk("spacing01", 32'(gnt_cyc - prev), 32'd10);
    prev = gnt_cyc;
    do_conv(2, 12'h100, 1);
    chk("spacing12", 32'(gnt_cyc - prev), 32'd10);
    prev = gnt_cyc;
    do_conv(3, 12'h199, 1);
    chk("spacing23", 32'(gnt_cyc - prev), 32'd10);

    // 4: two requesters held continuously alternate
    bin_in = {8'd0, 8'd7, 8'd0, 8'd42};
    req    = 4'b0101;
    do_conv(0, 12'h042, 0);
    do_conv(2, 12'h007, 0);
    do_conv(0, 12'h042, 0);
    do_conv(2, 12'h007, 0);
    req = 4'b0000;

    // 5: reset in the 4th shift cycle discards the conversion
    bin_in = {8'd0, 8'd0, 8'd99, 8'd0};
    req    = 4'b0010;
    seen = 0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (gnt != 4'b0) seen = 1;
    end
    chk("abort_gnt", 32'(gnt), 32'(4'b0010));
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done != 4'b0 || busy) seen = 1;
    end
    chk("abort_quiet", 32'(seen), 32'h0);
    bin_in = {8'd128, 8'd0, 8'd0, 8'd0};
    req    = 4'b1000;
    do_conv(3, 12'h128, 1);

    // 6: full operand sweep on requester 1
    for (int v = 0; v < 256; v++) begin
      bin_in = {8'd0, 8'd0, 8'(v), 8'd0};
      req    = 4'b0010;
      do_conv(1, to_bcd(v), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
